toggle_activity_monitor: RTL and testbench

TOGGLE_ACTIVITY_MONITOR -- requirements
Module: toggle_activity_monitor

---
 rtl/toggle_activity_monitor.sv | 147 ++++++++++++++
 tb/tb_toggle_activity_monitor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/toggle_activity_monitor.sv
`default_nettype none
// ============================================================================
// Module   : toggle_activity_monitor
// Purpose  : Watches a stream of ALU samples {a, b, y} and builds per-window
//            activity statistics. For each sample it counts the y bit toggles
//            against the previous accepted y. It also counts popcount(a) and
//            popcount(b). Every WINDOW accepted samples it hands out the
//            window sums plus the peak per-sample toggle count.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            in_valid/in_ready - sample handshake (a, b, y operands/result)
//            out_valid/out_ready - result handshake
//            out_toggles, out_hw_a, out_hw_b - saturating window sums
//            out_peak          - max per-sample y toggle count (0..8)
// Revision : 1.0 - initial release
// ============================================================================
module toggle_activity_monitor #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic [7:0]       y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_toggles,
    output logic [CNT_W-1:0] out_hw_a,
    output logic [CNT_W-1:0] out_hw_b,
    output logic [3:0]       out_peak
);

    localparam int                c_CNT_BITS = $clog2(WINDOW);
    localparam logic [c_CNT_BITS-1:0] c_LAST = c_CNT_BITS'(WINDOW - 1);

    localparam logic [0:0] c_ST_ACCUM = 1'b0;
    localparam logic [0:0] c_ST_HOLD  = 1'b1;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Adds a small per-sample count and clamps at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                                 input logic [3:0]       inc);
        logic [CNT_W:0] s;
        s = {1'b0, acc} + {{(CNT_W - 3){1'b0}}, inc};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    logic [0:0]            r_state;
    logic [c_CNT_BITS-1:0] r_cnt;
    logic [7:0]            r_y_prev;
    logic [CNT_W-1:0]      r_acc_tog;
    logic [CNT_W-1:0]      r_acc_hw_a;
    logic [CNT_W-1:0]      r_acc_hw_b;
    logic [3:0]            r_peak;
    logic [CNT_W-1:0]      r_out_tog;
    logic [CNT_W-1:0]      r_out_hw_a;
    logic [CNT_W-1:0]      r_out_hw_b;
    logic [3:0]            r_out_peak;

    logic                  w_accept;
    logic                  w_close;
    logic [3:0]            w_tog;
    logic [3:0]            w_peak_next;
    logic [CNT_W-1:0]      w_tog_sum;
    logic [CNT_W-1:0]      w_hw_a_sum;
    logic [CNT_W-1:0]      w_hw_b_sum;

    assign out_valid   = (r_state == c_ST_HOLD);
    assign out_toggles = r_out_tog;
    assign out_hw_a    = r_out_hw_a;
    assign out_hw_b    = r_out_hw_b;
    assign out_peak    = r_out_peak;

    // Only stall when closing this window would overwrite a result that is
    // still pending and not being taken this cycle.
    assign in_ready = ~(out_valid & ~out_ready & (r_cnt == c_LAST));

    assign w_accept    = in_valid & in_ready;
    assign w_close     = w_accept & (r_cnt == c_LAST);
    assign w_tog       = popcount8(y ^ r_y_prev);
    assign w_peak_next = (w_tog > r_peak) ? w_tog : r_peak;
    assign w_tog_sum   = sat_add(r_acc_tog, w_tog);
    assign w_hw_a_sum  = sat_add(r_acc_hw_a, popcount8(a));
    assign w_hw_b_sum  = sat_add(r_acc_hw_b, popcount8(b));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_ACCUM;
            r_cnt      <= '0;
            r_y_prev   <= 8'h00;
            r_acc_tog  <= '0;
            r_acc_hw_a <= '0;
            r_acc_hw_b <= '0;
            r_peak     <= 4'd0;
            r_out_tog  <= '0;
            r_out_hw_a <= '0;
            r_out_hw_b <= '0;
            r_out_peak <= 4'd0;
        end else begin
            if (w_accept) begin
                r_y_prev <= y;
                if (w_close) begin
                    // Window result includes the closing sample; accumulators
                    // restart empty for the next window.
                    r_cnt      <= '0;
                    r_out_tog  <= w_tog_sum;
                    r_out_hw_a <= w_hw_a_sum;
                    r_out_hw_b <= w_hw_b_sum;
                    r_out_peak <= w_peak_next;
                    r_acc_tog  <= '0;
                    r_acc_hw_a <= '0;
                    r_acc_hw_b <= '0;
                    r_peak     <= 4'd0;
                end else begin
                    r_cnt      <= r_cnt + 1'b1;
                    r_acc_tog  <= w_tog_sum;
                    r_acc_hw_a <= w_hw_a_sum;
                    r_acc_hw_b <= w_hw_b_sum;
                    r_peak     <= w_peak_next;
                end
            end

            case (r_state)
                c_ST_ACCUM: begin
                    if (w_close) r_state <= c_ST_HOLD;
                end
                c_ST_HOLD: begin
                    // A close on the consuming edge reloads and stays in HOLD.
                    if (out_ready && !w_close) r_state <= c_ST_ACCUM;
                end
                default: r_state <= c_ST_ACCUM;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_toggle_activity_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_toggle_activity_monitor
// Purpose  : Directed self-checking bench for toggle_activity_monitor with
//            WINDOW=4. A second instance with CNT_W=4 exercises saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_activity_monitor;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  y;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_toggles;
    logic [15:0] out_hw_a;
    logic [15:0] out_hw_b;
    logic [3:0]  out_peak;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [3:0]  s_out_toggles;
    logic [3:0]  s_out_hw_a;
    logic [3:0]  s_out_hw_b;
    logic [3:0]  s_out_peak;

    int n_checks;
    int n_pass;

    toggle_activity_monitor #(.WINDOW(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .out_toggles(out_toggles), .out_hw_a(out_hw_a), .out_hw_b(out_hw_b),
        .out_peak(out_peak)
    );

    toggle_activity_monitor #(.WINDOW(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .a(a), .b(b), .y(y), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_toggles(s_out_toggles), .out_hw_a(s_out_hw_a), .out_hw_b(s_out_hw_b),
        .out_peak(s_out_peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one sample for a single edge; inputs change 1 time unit after it.
    task automatic send(input logic [7:0] sa, input logic [7:0] sb, input logic [7:0] sy);
        in_valid = 1'b1; a = sa; b = sb; y = sy;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready_during got=%b exp=1", in_ready); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
        n_checks++;
        if (out_toggles !== 16'd0) $display("FAIL reset_toggles got=%0d exp=0", out_toggles); else n_pass++;
        n_checks++;
        if (out_hw_a !== 16'd0 || out_hw_b !== 16'd0) $display("FAIL reset_hw got=%0d/%0d exp=0/0", out_hw_a, out_hw_b); else n_pass++;
        n_checks++;
        if (out_peak !== 4'd0) $display("FAIL reset_peak got=%0d exp=0", out_peak); else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL reset_after got=v%b r%b exp=v0 r1", out_valid, in_ready); else n_pass++;
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        send(8'h0F, 8'h01, 8'hFF);
        send(8'h0F, 8'h01, 8'h00);
        send(8'h0F, 8'h01, 8'hFF);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL basic_early_valid got=%b exp=0", out_valid); else n_pass++;
        send(8'h0F, 8'h01, 8'h00);
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", out_valid); else n_pass++;
        n_checks++;
        if (out_toggles !== 16'd32) $display("FAIL basic_toggles got=%0d exp=32", out_toggles); else n_pass++;
        n_checks++;
        if (out_peak !== 4'd8) $display("FAIL basic_peak got=%0d exp=8", out_peak); else n_pass++;
        n_checks++;
        if (out_hw_a !== 16'd16 || out_hw_b !== 16'd4) $display("FAIL basic_hw got=%0d/%0d exp=16/4", out_hw_a, out_hw_b); else n_pass++;
        idle(1);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL basic_consumed got=%b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_gaps;
        out_ready = 1'b1;
        send(8'h00, 8'h00, 8'h01);
        idle(3);
        send(8'h00, 8'h00, 8'h03);
        send(8'h00, 8'h00, 8'h03);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL gaps_early_valid got=%b exp=0", out_valid); else n_pass++;
        send(8'h00, 8'h00, 8'h02);
        n_checks++;
        if (out_valid !== 1'b1 || out_toggles !== 16'd3) $display("FAIL gaps_toggles got=v%b t%0d exp=v1 t3", out_valid, out_toggles); else n_pass++;
        n_checks++;
        if (out_peak !== 4'd1 || out_hw_a !== 16'd0) $display("FAIL gaps_peak_hw got=p%0d a%0d exp=p1 a0", out_peak, out_hw_a); else n_pass++;
        idle(1);
    endtask

    task automatic test_back_to_back;
        // y_prev is 0x02 from the previous window.
        out_ready = 1'b0;
        send(8'hFF, 8'h00, 8'h03);
        send(8'hFF, 8'h00, 8'h03);
        send(8'hFF, 8'h00, 8'h03);
        send(8'hFF, 8'h00, 8'h03);
        n_checks++;
        if (out_valid !== 1'b1 || out_toggles !== 16'd1 || out_hw_a !== 16'd32)
            $display("FAIL bp_win1 got=v%b t%0d a%0d exp=v1 t1 a32", out_valid, out_toggles, out_hw_a); else n_pass++;
        send(8'h01, 8'h03, 8'h00);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL bp_ready_pending got=%b exp=1", in_ready); else n_pass++;
        send(8'h01, 8'h03, 8'h0F);
        send(8'h01, 8'h03, 8'h00);
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL bp_ready_stall got=%b exp=0", in_ready); else n_pass++;
        // Offer the closing sample while stalled; it must not be taken.
        in_valid = 1'b1; a = 8'h01; b = 8'h03; y = 8'h0F;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_toggles !== 16'd1 || out_hw_a !== 16'd32 || out_peak !== 4'd1)
            $display("FAIL bp_hold got=v%b t%0d a%0d p%0d exp=v1 t1 a32 p1", out_valid, out_toggles, out_hw_a, out_peak); else n_pass++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_toggles !== 16'd14) $display("FAIL bp_win2_toggles got=v%b t%0d exp=v1 t14", out_valid, out_toggles); else n_pass++;
        n_checks++;
        if (out_peak !== 4'd4 || out_hw_a !== 16'd4 || out_hw_b !== 16'd8)
            $display("FAIL bp_win2_misc got=p%0d a%0d b%0d exp=p4 a4 b8", out_peak, out_hw_a, out_hw_b); else n_pass++;
        out_ready = 1'b1;
        idle(1);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL bp_consumed got=%b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        send(8'h00, 8'h00, 8'hAA);
        send(8'h00, 8'h00, 8'h55);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL mid_after_rst got=v%b r%b exp=v0 r1", out_valid, in_ready); else n_pass++;
        for (int i = 0; i < 3; i++) send(8'h00, 8'h00, 8'h80);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL mid_early_valid got=%b exp=0", out_valid); else n_pass++;
        send(8'h00, 8'h00, 8'h80);
        n_checks++;
        if (out_valid !== 1'b1 || out_toggles !== 16'd1 || out_peak !== 4'd1)
            $display("FAIL mid_result got=v%b t%0d p%0d exp=v1 t1 p1", out_valid, out_toggles, out_peak); else n_pass++;
        idle(1);
    endtask

    task automatic test_saturation;
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send(8'h0F, 8'h01, 8'hFF);
        send(8'h0F, 8'h01, 8'h00);
        send(8'h0F, 8'h01, 8'hFF);
        send(8'h0F, 8'h01, 8'h00);
        n_checks++;
        if (s_out_valid !== 1'b1 || s_out_toggles !== 4'd15) $display("FAIL sat_toggles got=v%b t%0d exp=v1 t15", s_out_valid, s_out_toggles); else n_pass++;
        n_checks++;
        if (s_out_hw_a !== 4'd15 || s_out_hw_b !== 4'd4 || s_out_peak !== 4'd8)
            $display("FAIL sat_misc got=a%0d b%0d p%0d exp=a15 b4 p8", s_out_hw_a, s_out_hw_b, s_out_peak); else n_pass++;
        n_checks++;
        if (out_toggles !== 16'd32) $display("FAIL sat_wide_toggles got=%0d exp=32", out_toggles); else n_pass++;
        idle(1);
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 8'h00; b = 8'h00; y = 8'h00;
        #1;
        test_reset;
        test_basic;
        test_gaps;
        test_back_to_back;
        test_reset_mid;
        test_saturation;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
